// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, grant codes,
// port identifiers and the word-alignment helper.
package mem_arb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_SERVE_I = 4'b0010,
    ST_SERVE_D = 4'b0100,
    ST_DONE    = 4'b1000
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (I/D) handshakes and memory-side signals of the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          d_err;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic          mem_we;
  logic [DW-1:0] mem_rd;
  logic [1:0]    gnt;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    output i_rdata, i_ack, d_rdata, d_ack, d_err, mem_a, mem_wd, mem_we, gnt
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    input  i_rdata, i_ack, d_rdata, d_ack, d_err, mem_a, mem_wd, mem_we, gnt
  );
endinterface

// File: rtl/mem_port_arbiter_arb2_rr.sv
// Combinational two-way picker: round-robin against the last served port,
// or fixed priority to D when rr_en is low.
module arb2_rr
  import mem_arb_pkg::*;
(
  input  logic  req_i,
  input  logic  req_d,
  input  port_t last,
  input  logic  rr_en,
  output port_t pick
);

  always_comb begin
    pick = PORT_I;
    if (req_i && req_d) begin
      pick = (rr_en && last == PORT_D) ? PORT_I : PORT_D;
    end else if (req_d) begin
      pick = PORT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between an instruction-fetch port and a
// data port; one memory cycle per access followed by a one-cycle ack.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no access in flight, pick among pending requests
// ST_SERVE_I | memory driven with i_addr, read data captured at the edge
// ST_SERVE_D | memory driven with d_addr/d_wdata, write or read
// ST_DONE    | ack cycle; served port's req ignored, other port may start
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int RR_EN = 1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  state_t        state_q, state_d;
  port_t         last_q, last_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          d_err_q, d_err_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic          req_i_m, req_d_m, d_misaligned;
  port_t         pick;
  logic [AW-1:0] mem_a_c;
  logic [DW-1:0] mem_wd_c;
  logic          mem_we_c;
  logic [1:0]    gnt_c;

  // In the ack cycle the requester may still hold req, so mask the served port.
  assign req_i_m      = bus.i_req & ~(state_q == ST_DONE && last_q == PORT_I);
  assign req_d_m      = bus.d_req & ~(state_q == ST_DONE && last_q == PORT_D);
  assign d_misaligned = is_misaligned(bus.d_addr[1:0]);

  arb2_rr u_arb (
    .req_i (req_i_m),
    .req_d (req_d_m),
    .last  (last_q),
    .rr_en (RR_EN != 0),
    .pick  (pick)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (req_i_m || req_d_m) begin
          state_d = (pick == PORT_D) ? ST_SERVE_D : ST_SERVE_I;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE_I: begin
        i_rdata_d = bus.mem_rd;
        i_ack_d   = 1'b1;
        last_d    = PORT_I;
        state_d   = ST_DONE;
      end
      ST_SERVE_D: begin
        if (!bus.d_we) d_rdata_d = bus.mem_rd;
        d_ack_d = 1'b1;
        d_err_d = d_misaligned;
        last_d  = PORT_D;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_a_c  = '0;
    mem_wd_c = '0;
    mem_we_c = 1'b0;
    gnt_c    = GNT_NONE;
    case (state_q)
      ST_SERVE_I: begin
        mem_a_c = bus.i_addr;
        gnt_c   = GNT_I;
      end
      ST_SERVE_D: begin
        mem_a_c  = bus.d_addr;
        mem_wd_c = bus.d_wdata;
        mem_we_c = bus.d_we & ~d_misaligned;
        gnt_c    = GNT_D;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      last_q    <= PORT_I;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.i_rdata = i_rdata_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.d_err   = d_err_q;
  assign bus.mem_a   = mem_a_c;
  assign bus.mem_wd  = mem_wd_c;
  assign bus.mem_we  = mem_we_c;
  assign bus.gnt     = gnt_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance and a
// fixed-priority instance share stimulus, each with its own word memory.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] mem    [0:15];
  logic [31:0] mem_fp [0:15];

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus_fp ();

  mem_port_arbiter #(.AW(32), .DW(32), .RR_EN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .RR_EN(0)) dut_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_fp.slave)
  );

  always #5 clk = ~clk;

  assign bus_fp.i_req   = bus.i_req;
  assign bus_fp.i_addr  = bus.i_addr;
  assign bus_fp.d_req   = bus.d_req;
  assign bus_fp.d_we    = bus.d_we;
  assign bus_fp.d_addr  = bus.d_addr;
  assign bus_fp.d_wdata = bus.d_wdata;

  assign bus.mem_rd    = mem[bus.mem_a[5:2]];
  assign bus_fp.mem_rd = mem_fp[bus_fp.mem_a[5:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 16; k++) begin
        mem[k]    <= (k == 2) ? 32'hDEADBEEF : (32'hC0DE0000 | k);
        mem_fp[k] <= (k == 2) ? 32'hDEADBEEF : (32'hC0DE0000 | k);
      end
    end else begin
      if (bus.mem_we)    mem[bus.mem_a[5:2]]       <= bus.mem_wd;
      if (bus_fp.mem_we) mem_fp[bus_fp.mem_a[5:2]] <= bus_fp.mem_wd;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A granted port must still be requesting while its access is on the bus.
  always @(negedge clk) begin
    if (!reset && bus.gnt == 2'b01) chk("proto_i_req_held", 64'(bus.i_req), 64'd1);
    if (!reset && bus.gnt == 2'b10) chk("proto_d_req_held", 64'(bus.d_req), 64'd1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_seq [0:7];
    exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0001;
    exp_seq[2] = 4'b0100; exp_seq[3] = 4'b0010;
    exp_seq[4] = 4'b1000; exp_seq[5] = 4'b0001;
    exp_seq[6] = 4'b0100; exp_seq[7] = 4'b0010;

    reset       = 1'b1;
    mem_init    = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    step();
    step();
    mem_init = 1'b0;

    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_flags", 64'({bus.i_ack, bus.d_ack, bus.d_err, bus.mem_we}), 64'd0);
    chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'd0);
    chk("rst_mem_bus", {bus.mem_a, bus.mem_wd}, 64'd0);

    // single D read of word 2
    reset = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h8;
    chk("rd_c0_gnt", 64'(bus.gnt), 64'd0);
    step();
    chk("rd_c1_gnt", 64'(bus.gnt), 64'b10);
    chk("rd_c1_mem_a", 64'(bus.mem_a), 64'h8);
    chk("rd_c1_ack", 64'(bus.d_ack), 64'd0);
    step();
    chk("rd_c2_ack_gnt", 64'({bus.d_ack, bus.d_err, bus.gnt}), 64'b1000);
    chk("rd_c2_rdata", 64'(bus.d_rdata), 64'hDEADBEEF);
    bus.d_req = 1'b0;
    step();
    chk("rd_c3_ack_clr", 64'(bus.d_ack), 64'd0);

    // write 0x10, then D holds req through the ack for a read-back
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'h12345678;
    step();
    chk("wr_c1_we_wd", {31'd0, bus.mem_we, bus.mem_wd}, {31'd0, 1'b1, 32'h12345678});
    step();
    chk("wr_c2_ack_we", 64'({bus.d_ack, bus.mem_we}), 64'b10);
    chk("wr_c2_rdata_held", 64'(bus.d_rdata), 64'hDEADBEEF);
    bus.d_we = 1'b0;
    step();
    chk("rb_idle_no_regrant", 64'({bus.gnt, bus.d_ack}), 64'd0);
    step();
    chk("rb_c1_gnt", 64'(bus.gnt), 64'b10);
    step();
    chk("rb_c2_ack", 64'(bus.d_ack), 64'd1);
    chk("rb_c2_rdata", 64'(bus.d_rdata), 64'h12345678);
    bus.d_req = 1'b0;
    step();

    // last=D: round-robin now picks I, fixed priority still picks D
    bus.i_req = 1'b1; bus.i_addr = 32'h20;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h8;
    step();
    chk("rr_first_gnt", 64'(bus.gnt), 64'b01);
    chk("fp_first_gnt", 64'(bus_fp.gnt), 64'b10);
    step();
    chk("rr_i_ack_rdata", {31'd0, bus.i_ack, bus.i_rdata}, {31'd0, 1'b1, 32'hC0DE0008});
    chk("fp_d_ack", 64'({bus_fp.d_ack, bus_fp.i_ack}), 64'b10);
    step();
    chk("rr_second_gnt", 64'(bus.gnt), 64'b10);
    chk("fp_second_gnt", 64'(bus_fp.gnt), 64'b01);
    step();
    chk("rr_d_ack_rdata", {31'd0, bus.d_ack, bus.d_rdata}, {31'd0, 1'b1, 32'hDEADBEEF});
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    step();

    // contention straight after reset: D, I, D, I every 2 cycles
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h24;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h8;
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("cont_c%0d_gnt_acks", c + 1),
          64'({bus.gnt, bus.i_ack, bus.d_ack}), 64'(exp_seq[c]));
    end
    chk("cont_i_rdata", 64'(bus.i_rdata), 64'hC0DE0009);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    step();

    // misaligned write must not touch memory; misaligned read still returns data
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h11; bus.d_wdata = 32'hFFFF0000;
    step();
    chk("mis_wr_we", {31'd0, bus.mem_we, bus.mem_a}, {31'd0, 1'b0, 32'h11});
    step();
    chk("mis_wr_ack_err", 64'({bus.d_ack, bus.d_err}), 64'b11);
    bus.d_req = 1'b0;
    step();
    chk("mis_wr_err_clr", 64'({bus.d_ack, bus.d_err}), 64'b00);
    chk("mis_wr_mem4", 64'(mem[4]), 64'h12345678);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h13;
    step();
    step();
    chk("mis_rd_ack_err", 64'({bus.d_ack, bus.d_err}), 64'b11);
    chk("mis_rd_rdata", 64'(bus.d_rdata), 64'h12345678);
    bus.d_req = 1'b0;
    step();

    // I holds req through its ack: IDLE in between, 3-cycle spacing
    bus.i_req = 1'b1; bus.i_addr = 32'h20;
    step();
    chk("ihold_c1_gnt", 64'(bus.gnt), 64'b01);
    step();
    chk("ihold_c2_ack", 64'({bus.i_ack, bus.gnt}), 64'b100);
    step();
    chk("ihold_c3_idle", 64'({bus.i_ack, bus.gnt}), 64'b000);
    step();
    chk("ihold_c4_gnt", 64'(bus.gnt), 64'b01);
    step();
    chk("ihold_c5_ack", 64'(bus.i_ack), 64'd1);
    bus.i_req = 1'b0;
    step();

    // reset during a D write: write lands, no ack, outputs cleared
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h4; bus.d_wdata = 32'hCAFEF00D;
    step();
    chk("rstw_serve_we", 64'({bus.gnt, bus.mem_we}), 64'b101);
    reset = 1'b1;
    step();
    chk("rstw_mem1", 64'(mem[1]), 64'hCAFEF00D);
    chk("rstw_flags", 64'({bus.gnt, bus.i_ack, bus.d_ack, bus.d_err, bus.mem_we}), 64'd0);
    chk("rstw_rdata", {bus.i_rdata, bus.d_rdata}, 64'd0);
    chk("rstw_mem_bus", {bus.mem_a, bus.mem_wd}, 64'd0);
    bus.d_req = 1'b0;
    step();
    chk("rstw_no_ack", 64'(bus.d_ack), 64'd0);
    reset = 1'b0;
    step();
    chk("rstw_idle", 64'({bus.gnt, bus.d_ack}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
